// File: rtl/and_tree_pkg.sv
// Shared definitions for the round-robin AND-tree scheduler.
// FSM encodings and the id-width helper.
package and_tree_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_BUSY = 2'd1;
  localparam state_t S_OUT  = 2'd2;

  // Width of a requester index; a lone bit even for two requesters.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/and_tree_red.sv
// Balanced combinational AND-reduction tree.
// One level per halving, log2(WIDTH) levels deep.
module and_tree_red #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  localparam int LVLS = $clog2(WIDTH);

  for (genvar k = 0; k <= LVLS; k++) begin : lv
    logic [(WIDTH>>k)-1:0] v;
    if (k == 0) begin : g_leaf
      assign v = din;
    end else begin : g_node
      for (genvar j = 0; j < (WIDTH >> k); j++) begin : g_and
        assign v[j] = lv[k-1].v[2*j] & lv[k-1].v[2*j+1];
      end
    end
  end

  assign dout = lv[LVLS].v[0];

endmodule

// File: rtl/and_tree_rr_sched.sv
// Round-robin packet scheduler in front of a shared AND tree.
// Grant is locked per packet; one registered result per packet.
module and_tree_rr_sched
  import and_tree_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_data,
  output logic [id_w(NREQ)-1:0]   res_id,
  output logic [CNTW-1:0]         res_beats,
  output logic                    busy
);

  localparam int IDW = id_w(NREQ);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_nx;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  pick;
  logic            acc;
  logic            acc_nx;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nx;
  logic [WIDTH-1:0] beat;
  logic            valid_g;
  logic            last_g;
  logic            red;
  logic            take;

  // First valid requester at or above p, wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_pick(
    input logic [NREQ-1:0] v,
    input logic [IDW-1:0]  p
  );
    logic [IDW-1:0] r;
    logic           hit;
    int             idx;
    r   = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!hit && v[idx]) begin
        r   = IDW'(idx);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  assign pick = rr_pick(req_valid, ptr);

  always_comb begin
    beat    = '0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        beat    = req_data[i*WIDTH +: WIDTH];
        valid_g = req_valid[i];
        last_g  = req_last[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state == S_BUSY) && (gnt == IDW'(i));
    end
  end

  and_tree_red #(
    .WIDTH(WIDTH)
  ) u_red (
    .din (beat),
    .dout(red)
  );

  assign take   = (state == S_BUSY) && valid_g;
  assign acc_nx = acc & red;
  assign cnt_nx = (&cnt) ? cnt : cnt + 1'b1;
  assign ptr_nx = (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      acc       <= 1'b1;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= 1'b0;
      res_id    <= '0;
      res_beats <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (|req_valid) begin
            gnt   <= pick;
            acc   <= 1'b1;
            cnt   <= '0;
            state <= S_BUSY;
          end
        end
        (state == S_BUSY): begin
          if (take) begin
            acc <= acc_nx;
            cnt <= cnt_nx;
            if (last_g) begin
              res_data  <= acc_nx;
              res_id    <= gnt;
              res_beats <= cnt_nx;
              res_valid <= 1'b1;
              ptr       <= ptr_nx;
              state     <= S_OUT;
            end
          end
        end
        (state == S_OUT): begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_tree_rr_sched.sv
// Randomized bench for and_tree_rr_sched against a packet-level model.
// Every cycle the DUT outputs are compared with the model.
module tb_and_tree_rr_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNTW  = 8;
  localparam int IDW   = 2;
  localparam int SATV  = (1 << CNTW) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_data;
  logic [IDW-1:0]        res_id;
  logic [CNTW-1:0]       res_beats;
  logic                  busy;

  and_tree_rr_sched #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .CNTW (CNTW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_last (req_last),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_id   (res_id),
    .res_beats(res_beats),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Sources: pending beats {last, data} per requester
  logic [WIDTH:0] q [NREQ][$];
  int hold [NREQ];
  int gap_pct;
  int rdy_pct;

  // Model: 0 idle, 1 packet in flight, 2 result waiting
  int ph;
  int g;
  int ptr;
  int beats;
  bit andv;
  bit m_rd;
  int m_rid;
  int m_rb;
  int ids [$];

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic push_beat(input int r, input logic [WIDTH-1:0] d,
                           input bit l);
    q[r].push_back({l, d});
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (q[i].size() > 0) && (hold[i] == 0) &&
                     ($urandom_range(0, 99) >= gap_pct);
      if (hold[i] > 0) hold[i]--;
      if (q[i].size() > 0)
        {req_last[i], req_data[i*WIDTH +: WIDTH]} = q[i][0];
      else
        {req_last[i], req_data[i*WIDTH +: WIDTH]} = (WIDTH+1)'($urandom);
    end
    res_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic model();
    int p;
    if (rst) begin
      ph = 0; ptr = 0; m_rd = 0; m_rid = 0; m_rb = 0;
    end else begin
      case (ph)
        0: begin
          p = pick(req_valid, ptr);
          if (p >= 0) begin
            g = p; andv = 1; beats = 0; ph = 1;
          end
        end
        1: begin
          if (req_valid[g]) begin
            andv = andv & (&req_data[g*WIDTH +: WIDTH]);
            beats++;
            void'(q[g].pop_front());
            if (req_last[g]) begin
              m_rd  = andv;
              m_rid = g;
              m_rb  = (beats > SATV) ? SATV : beats;
              ptr   = (g + 1) % NREQ;
              ph    = 2;
            end
          end
        end
        default: begin
          if (res_ready) begin
            ph = 0;
            ids.push_back(m_rid);
          end
        end
      endcase
    end
  endtask

  task automatic check();
    logic [NREQ-1:0] er;
    er = (ph == 1) ? NREQ'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("res_valid", 32'(res_valid), 32'(ph == 2));
    chk("res_data", 32'(res_data), 32'(m_rd));
    chk("res_id", 32'(res_id), 32'(m_rid));
    chk("res_beats", 32'(res_beats), 32'(m_rb));
  endtask

  task automatic cyc();
    drive();
    @(posedge clk);
    model();
    #1;
    check();
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while ((ph != 0 || pending()) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 32'(n >= budget), 0);
  endtask

  task automatic run_until_beats(input int want_ph, input int want_b);
    int n = 0;
    while (!(ph == want_ph && (want_ph != 1 || beats == want_b)) &&
           n < 200) begin
      cyc();
      n++;
    end
    chk("wait_timeout", 32'(n >= 200), 0);
  endtask

  initial begin
    int seq [5];
    int nb;
    logic [WIDTH-1:0] d;
    int len;
    int r;
    seq = '{0, 1, 2, 3, 0};
    rst = 1; req_valid = '0; req_data = '0; req_last = '0;
    res_ready = 0; gap_pct = 0; rdy_pct = 100;
    ph = 0; g = 0; ptr = 0; beats = 0; andv = 1;
    m_rd = 0; m_rid = 0; m_rb = 0;
    for (int i = 0; i < NREQ; i++) hold[i] = 0;

    // Reset with everyone valid, then round-robin of 1-beat packets
    for (int i = 0; i < NREQ; i++) begin
      push_beat(i, 8'hFF, 1);
      push_beat(i, 8'hFF, 1);
    end
    repeat (3) cyc();
    rst = 0;
    drain(200);
    chk("rr_count", 32'(ids.size()), 8);
    for (int k = 0; k < 5 && k < ids.size(); k++)
      chk("rr_seq", 32'(ids[k]), 32'(seq[k]));

    // Single-beat packets
    push_beat(2, 8'hFF, 1);
    drain(50);
    chk("single_ff_data", 32'(res_data), 1);
    chk("single_ff_id", 32'(res_id), 2);
    chk("single_ff_beats", 32'(res_beats), 1);
    push_beat(2, 8'hEF, 1);
    drain(50);
    chk("single_ef_data", 32'(res_data), 0);

    // Multi-beat accumulation
    push_beat(1, 8'hFF, 0); push_beat(1, 8'hFF, 0); push_beat(1, 8'h7F, 1);
    drain(50);
    chk("multi_7f_data", 32'(res_data), 0);
    chk("multi_7f_beats", 32'(res_beats), 3);
    push_beat(1, 8'hFF, 0); push_beat(1, 8'hFF, 0); push_beat(1, 8'hFF, 1);
    drain(50);
    chk("multi_ff_data", 32'(res_data), 1);
    chk("multi_ff_beats", 32'(res_beats), 3);

    // Result backpressure for 5 cycles
    rdy_pct = 0;
    push_beat(3, 8'hFF, 1);
    run_until_beats(2, 0);
    repeat (5) cyc();
    rdy_pct = 100;
    drain(50);
    chk("bp_id", 32'(res_id), 3);

    // Granted requester stalls mid-packet while others wait
    push_beat(0, 8'hFF, 0); push_beat(0, 8'hFF, 0); push_beat(0, 8'hFF, 1);
    push_beat(1, 8'h00, 1); push_beat(2, 8'hFF, 1);
    run_until_beats(1, 1);
    hold[0] = 3;
    drain(100);

    // Reset after 2 of 4 beats drops the packet
    push_beat(0, 8'h00, 0); push_beat(0, 8'hFF, 0);
    push_beat(0, 8'hFF, 0); push_beat(0, 8'hFF, 1);
    run_until_beats(1, 2);
    nb = ids.size();
    rst = 1;
    for (int i = 0; i < NREQ; i++) q[i].delete();
    cyc();
    rst = 0;
    push_beat(0, 8'hFF, 0); push_beat(0, 8'hFF, 1);
    drain(50);
    chk("rst_results", 32'(ids.size() - nb), 1);
    chk("rst_data", 32'(res_data), 1);
    chk("rst_beats", 32'(res_beats), 2);

    // Beat counter saturation
    for (int k = 0; k < 300; k++) push_beat(1, 8'hFF, k == 299);
    drain(1000);
    chk("sat_beats", 32'(res_beats), 255);
    chk("sat_data", 32'(res_data), 1);

    // Random traffic with input gaps and result backpressure
    gap_pct = 25;
    rdy_pct = 60;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        r   = $urandom_range(0, NREQ - 1);
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++) begin
          d = ($urandom_range(0, 4) == 0) ? WIDTH'($urandom) : 8'hFF;
          push_beat(r, d, b == len - 1);
        end
      end
      cyc();
    end
    drain(5000);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
